// File: rtl/seq_u_arrbam_mul.sv
// Sequential unsigned broken-array approximate multiplier: one partial-product row per clock,
// runtime horizontal/vertical break levels. Optional error monitor enabled by BAM_ERR_MON_EN.
module seq_u_arrbam_mul #(
  parameter int N  = 8,
  parameter int HW = $clog2(N + 1),
  parameter int VW = $clog2(2 * N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic [HW-1:0]   h_cfg,
  input  logic [VW-1:0]   v_cfg,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  out_prod
`ifdef BAM_ERR_MON_EN
  ,
  output logic [2*N-1:0]  err_abs,
  output logic [2*N-1:0]  err_max
`endif
);

  localparam int CW = VW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     a_reg, b_reg;
  logic [VW-1:0]    v_eff_reg;
  logic [HW-1:0]    row_reg;
  logic [2*N-1:0]   acc_reg, prod_reg;

  logic [HW-1:0]    h_eff;
  logic [VW-1:0]    v_eff;
  logic             accept, last_row, b_bit;
  logic [N-1:0]     b_shift, pp;
  logic [2*N-1:0]   row_term, acc_sum;

  // Out-of-range break levels saturate to "drop everything" on that axis.
  assign h_eff = (h_cfg > HW'(N)) ? HW'(N) : h_cfg;
  assign v_eff = (v_cfg > VW'(2 * N)) ? VW'(2 * N) : v_cfg;

  assign accept   = in_valid & in_ready;
  assign last_row = (row_reg == HW'(N - 1));
  assign b_shift  = b_reg >> row_reg;
  assign b_bit    = b_shift[0];

  // Keep term a[i]&b[row] only when its weight i+row reaches the vertical break.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pp
      assign pp[gi] = a_reg[gi] & b_bit &
                      ((CW'(gi) + CW'(row_reg)) >= CW'(v_eff_reg));
    end
  endgenerate

  assign row_term = {{N{1'b0}}, pp} << row_reg;
  assign acc_sum  = acc_reg + row_term;
  assign out_prod = prod_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (h_eff == HW'(N)) ? DONE : RUN;
      end
      RUN: begin
        if (last_row) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // prod_reg is loaded only on entry to DONE so the last result survives the next RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      v_eff_reg <= '0;
      row_reg   <= '0;
      acc_reg   <= '0;
      prod_reg  <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      v_eff_reg <= v_eff;
      row_reg   <= h_eff;
      acc_reg   <= '0;
      if (h_eff == HW'(N)) prod_reg <= '0;
    end else if (state_reg == RUN) begin
      acc_reg <= acc_sum;
      row_reg <= row_reg + 1'b1;
      if (last_row) prod_reg <= acc_sum;
    end
  end

`ifdef BAM_ERR_MON_EN
  logic [2*N-1:0] exact_prod;
  logic [2*N-1:0] err_max_reg;

  assign exact_prod = {{N{1'b0}}, a_reg} * {{N{1'b0}}, b_reg};
  assign err_abs    = exact_prod - prod_reg;
  assign err_max    = err_max_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_max_reg <= '0;
    else if (out_valid && out_ready && (err_abs > err_max_reg)) err_max_reg <= err_abs;
  end
`endif

endmodule

// File: tb/tb_seq_u_arrbam_mul.sv
// Self-checking bench for seq_u_arrbam_mul: directed vector table, random ops against a
// sum-of-kept-terms reference, plus backpressure and mid-operation reset sequences.
module tb_seq_u_arrbam_mul;
  localparam int N  = 8;
  localparam int HW = $clog2(N + 1);
  localparam int VW = $clog2(2 * N + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [N-1:0]    a, b;
  logic [HW-1:0]   h_cfg;
  logic [VW-1:0]   v_cfg;
  logic            out_valid, out_ready;
  logic [2*N-1:0]  out_prod;
`ifdef BAM_ERR_MON_EN
  logic [2*N-1:0]  err_abs, err_max;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_u_arrbam_mul #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .h_cfg     (h_cfg),
    .v_cfg     (v_cfg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod)
`ifdef BAM_ERR_MON_EN
    ,
    .err_abs   (err_abs),
    .err_max   (err_max)
`endif
  );

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    int             h;
    int             v;
    logic [2*N-1:0] prod;
    int             lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sum of every kept partial-product term, directly from the break rules.
  function automatic logic [2*N-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                           input int h, input int v);
    int he, ve;
    longint s;
    he = (h > N) ? N : h;
    ve = (v > 2 * N) ? 2 * N : v;
    s = 0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if (j >= he && i + j >= ve && ma[i] && mb[j]) s += longint'(1) << (i + j);
    return s[2*N-1:0];
  endfunction

  function automatic int model_lat(input int h);
    return N - ((h > N) ? N : h) + 1;
  endfunction

  // Issue one operation; junk is presented on the inputs (with in_valid) while busy.
  task automatic do_op(input logic [N-1:0] oa, input logic [N-1:0] ob, input int h, input int v,
                       input logic [2*N-1:0] exp_prod, input int exp_lat);
    int lat;
    check("in_ready_idle", in_ready, 1'b1);
    a = oa; b = ob; h_cfg = HW'(h); v_cfg = VW'(v); in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    a = N'($urandom); b = N'($urandom); h_cfg = '0; v_cfg = '0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("out_valid_seen", out_valid, 1'b1);
    check("latency", lat, exp_lat);
    check("out_prod", out_prod, exp_prod);
    check("in_ready_done", in_ready, 1'b0);
`ifdef BAM_ERR_MON_EN
    check("err_abs", err_abs, ({8'b0, oa} * {8'b0, ob}) - exp_prod);
`endif
    $display("op a=%02h b=%02h h=%0d v=%0d prod=%04h exp=%04h lat=%0d", oa, ob, h, v,
             out_prod, exp_prod, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("out_prod_hold", out_prod, exp_prod);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    int rh, rv, rlat;

    vecs[0] = '{8'hFF, 8'hFF, 5, 12, 16'hB000, 4};
    vecs[1] = '{8'hFF, 8'hFF, 0, 0, 16'hFE01, 9};
    vecs[2] = '{8'h80, 8'h80, 5, 12, 16'h4000, 4};
    vecs[3] = '{8'h7F, 8'h1F, 5, 12, 16'h0000, 4};
    vecs[4] = '{8'hA5, 8'h3C, 8, 0, 16'h0000, 1};
    vecs[5] = '{8'hA5, 8'h3C, 15, 0, 16'h0000, 1};
    vecs[6] = '{8'h03, 8'h05, 0, 0, 16'h000F, 9};
    vecs[7] = '{8'hFF, 8'hFF, 0, 31, 16'h0000, 9};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; h_cfg = '0; v_cfg = '0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_prod", out_prod, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++)
      do_op(vecs[k].a, vecs[k].b, vecs[k].h, vecs[k].v, vecs[k].prod, vecs[k].lat);

    for (int k = 0; k < 40; k++) begin
      ra = N'($urandom); rb = N'($urandom);
      rh = (k % 4 == 0) ? 0 : int'($urandom_range(0, 15));
      rv = (k % 4 == 1) ? 0 : int'($urandom_range(0, 31));
      rlat = model_lat(rh);
      do_op(ra, rb, rh, rv, model(ra, rb, rh, rv), rlat);
    end

    // Backpressure: hold DONE with out_ready low while offering a new operation.
    a = 8'hFF; b = 8'hFF; h_cfg = '0; v_cfg = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 8 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    check("bp_valid", out_valid, 1'b1);
    a = 8'h11; b = 8'h22; h_cfg = 4'd8; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_prod", out_prod, 16'hFE01);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    $display("backpressure prod=%04h", out_prod);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", out_valid, 1'b0);

    // Reset in the middle of RUN abandons the operation.
    a = 8'hFF; b = 8'hFF; h_cfg = '0; v_cfg = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_prod", out_prod, '0);
    $display("mid-run reset in_ready=%0b out_valid=%0b", in_ready, out_valid);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) check("mid_rst_no_pulse", out_valid, 1'b0);
    end
    do_op(8'h03, 8'h05, 0, 0, 16'h000F, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
